instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch stage of the MIPS CPU, directly upstream of the combinational instruction ROM.
- Holds the program counter and drives the ROM address. Captures the returned instruction word into the IF/ID pipeline register.
- Selects the next PC from sequential, branch, jump, jump-register, exception and interrupt sources.
- Honours stall and flush requests from the hazard unit.

Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset (bit 31 = supervisor mode).
- ILLOP_PC, 32'h8000_0004, illegal-instruction exception vector.
- XADR_PC, 32'h8000_0008, interrupt vector.
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- flush  in  1  load bubble into IF/ID.
- br_taken  in  1  branch resolved taken in ID.
- br_target  in  32  branch target.
- jump  in  1  J/JAL in ID.
- jump_target  in  32  jump target.
- jr  in  1  JR/JALR in ID.
- jr_target  in  32  register target.
- illop  in  1  illegal instruction decoded in ID.
- irq  in  1  level interrupt request.
- rom_addr  out  32  instruction address to ROM.
- rom_data  in  32  instruction word from ROM (combinational, same cycle).
- pc  out  32  current fetch PC.
- id_instr  out  32  IF/ID instruction.
- id_pc_plus4  out  32  IF/ID PC+4.
- id_valid  out  1  IF/ID holds a real instruction.
- irq_ack  out  1  one-cycle pulse: interrupt taken.
- exc_epc  out  32  return address captured on interrupt.
- fetch_count  out  32  number of instructions loaded valid into IF/ID.

Behaviour:
- Reset (synchronous, highest priority; may arrive mid-operation, redirect or stall):
  - pc=RESET_PC, id_instr=NOP_WORD, id_pc_plus4=0, id_valid=0.
  - irq_ack=0, exc_epc=0, fetch_count=0.
- rom_addr = pc, combinationally. ROM latency is zero; rom_data is sampled at the edge ending the cycle.
- pc_plus4 = {pc[31], pc[30:0]+4}. Supervisor bit 31 is preserved; bits 30:0 wrap modulo 2^31.
- Next-PC priority, highest first:
  1. illop -> ILLOP_PC
  2. irq_take -> XADR_PC
  3. br_taken -> br_target
  4. jr -> jr_target
  5. jump -> jump_target
  6. stall -> hold pc
  7. otherwise -> pc_plus4
- Redirect targets are used verbatim, including bit 31.
- irq_take = irq & ~pc[31] & ~illop & ~br_taken & ~jr & ~jump & ~reset.
  - Interrupts are ignored in supervisor mode.
  - Interrupts are deferred while any control-flow redirect is pending, so EPC is never a wrong-path address.
  - stall does not block irq_take.
- On irq_take:
  - exc_epc <= pc (the discarded fetch).
  - irq_ack=1 for exactly one cycle.
  - A level irq that is still high is re-evaluated each cycle; after vectoring, pc[31]=1 masks it.
- IF/ID update, highest priority first:
  1. Any redirect (illop, irq_take, br_taken, jr, jump) or flush -> id_instr=NOP_WORD, id_valid=0. id_pc_plus4 = pc_plus4 (for debug).
  2. stall -> hold all IF/ID fields.
  3. otherwise -> id_instr=rom_data, id_pc_plus4=pc_plus4, id_valid=1.
- Simultaneous redirect and stall: redirect wins. PC takes the target; IF/ID takes a bubble.
- Simultaneous flush and stall (no redirect): PC holds; IF/ID takes a bubble.
- fetch_count increments by 1 on each edge where IF/ID is loaded with id_valid=1; wraps at 2^32 to 0.
- exc_epc holds its value between interrupts.

Test Plan:
- Reset then free-run 4 cycles, rom_data = 32'h3c11_4000 / 32'h2631_0004 -> rom_addr 80000000, 80000004, 80000008, 8000000C. id_instr follows one cycle behind. id_valid=1 from cycle 2; fetch_count=3 after cycle 4.
- pc=8000_0010 with stall=1 for 2 cycles -> pc and IF/ID frozen, fetch_count unchanged. Release -> pc=8000_0014.
- pc=0000_0040, br_taken=1, br_target=0000_0054, stall=1 same cycle -> pc=0000_0054, id_valid=0. The next cycle loads the ROM word at 0x54.
- User mode pc=0000_0020, irq=1, no redirect -> pc=XADR_PC, exc_epc=0000_0020, irq_ack one cycle. irq held high afterwards -> no second ack.
- irq=1 and jump=1 (jump_target=0000_0058) same cycle -> pc=0000_0058, no ack. Next cycle irq taken with exc_epc=0000_0058.
- illop=1 and br_taken=1 same cycle -> pc=8000_0004. Assert reset during a stall -> pc=8000_0000, all outputs at reset values next edge.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the program counter, drives the combinational
// instruction ROM address and loads the returned word into the IF/ID register.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   stall, flush             hazard-unit hold / bubble requests
//   br_taken, br_target      taken branch from ID and its target
//   jump, jump_target        J/JAL from ID and its target
//   jr, jr_target            JR/JALR from ID and the register target
//   illop                    illegal instruction decoded in ID
//   irq                      level interrupt request (ignored in supervisor mode)
//   rom_addr, rom_data       ROM address (= pc) and same-cycle instruction word
//   pc                       current fetch PC
//   id_instr, id_pc_plus4,
//   id_valid                 IF/ID pipeline register
//   irq_ack, exc_epc         interrupt-taken pulse and captured return address
//   fetch_count              count of valid instructions loaded into IF/ID
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        illop,
  input  logic        irq,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        irq_ack,
  output logic [31:0] exc_epc,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        irq_take;
  logic        redirect;

  assign rom_addr = pc;

  // Supervisor bit is sticky across sequential fetch; only the low 31 bits wrap.
  assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

  // Interrupts wait for any pending control-flow change so EPC is never a
  // wrong-path address; stall deliberately does not block them.
  assign irq_take = irq & ~pc[31] & ~illop & ~br_taken & ~jr & ~jump & ~reset;
  assign redirect = illop | irq_take | br_taken | jr | jump;

  always_comb begin
    next_pc = pc_plus4;
    if (illop)         next_pc = ILLOP_PC;
    else if (irq_take) next_pc = XADR_PC;
    else if (br_taken) next_pc = br_target;
    else if (jr)       next_pc = jr_target;
    else if (jump)     next_pc = jump_target;
    else if (stall)    next_pc = pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      id_instr    <= NOP_WORD;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
      irq_ack     <= 1'b0;
      exc_epc     <= '0;
      fetch_count <= '0;
    end else begin
      pc      <= next_pc;
      irq_ack <= irq_take;
      if (irq_take) exc_epc <= pc;

      if (redirect || flush) begin
        id_instr    <= NOP_WORD;
        id_pc_plus4 <= pc_plus4;
        id_valid    <= 1'b0;
      end else if (!stall) begin
        id_instr    <= rom_data;
        id_pc_plus4 <= pc_plus4;
        id_valid    <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        br_taken = 1'b0, jump = 1'b0, jr = 1'b0, illop = 1'b0, irq = 1'b0;
  logic [31:0] br_target = '0, jump_target = '0, jr_target = '0;
  logic [31:0] rom_addr, rom_data, pc, id_instr, id_pc_plus4, exc_epc, fetch_count;
  logic        id_valid, irq_ack;

  logic [31:0] rom_mem [64];
  assign rom_data = rom_mem[rom_addr[7:2]];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pp4, m_epc, m_cnt;
  logic        m_valid, m_ack;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC(RESET_PC), .ILLOP_PC(ILLOP_PC), .XADR_PC(XADR_PC), .NOP_WORD(NOP_WORD)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .br_taken(br_taken), .br_target(br_target),
    .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_target(jr_target),
    .illop(illop), .irq(irq),
    .rom_addr(rom_addr), .rom_data(rom_data), .pc(pc),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
    .irq_ack(irq_ack), .exc_epc(exc_epc), .fetch_count(fetch_count)
  );

  task automatic clr();
    reset = 0; stall = 0; flush = 0; br_taken = 0; jump = 0; jr = 0;
    illop = 0; irq = 0;
  endtask

  // Compute what the stage should hold after the coming edge from the current
  // inputs, advance one clock, then commit the prediction.
  task automatic cycle();
    logic [31:0] n_pc, n_instr, n_pp4, n_epc, n_cnt, seq;
    logic        n_valid, n_ack, take, redir;
    seq     = {m_pc[31], 31'((m_pc[30:0] + 31'd4) % (32'h8000_0000))};
    n_pc    = m_pc;  n_instr = m_instr; n_pp4 = m_pp4; n_epc = m_epc;
    n_cnt   = m_cnt; n_valid = m_valid;
    if (reset) begin
      n_pc = RESET_PC; n_instr = NOP_WORD; n_pp4 = 0; n_valid = 0;
      n_ack = 0; n_epc = 0; n_cnt = 0;
    end else begin
      take  = irq && !m_pc[31] && !illop && !br_taken && !jr && !jump;
      redir = illop || take || br_taken || jr || jump;
      if (illop)         n_pc = ILLOP_PC;
      else if (take)     n_pc = XADR_PC;
      else if (br_taken) n_pc = br_target;
      else if (jr)       n_pc = jr_target;
      else if (jump)     n_pc = jump_target;
      else if (!stall)   n_pc = seq;
      n_ack = take;
      if (take) n_epc = m_pc;
      if (redir || flush) begin
        n_instr = NOP_WORD; n_valid = 0; n_pp4 = seq;
      end else if (!stall) begin
        n_instr = rom_mem[m_pc[7:2]]; n_valid = 1; n_pp4 = seq; n_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid;
    m_ack = n_ack; m_epc = n_epc; m_cnt = n_cnt;
  endtask

  task automatic test_reset();
    clr(); reset = 1; cycle(); clr();
    n_cmp++; if (pc !== RESET_PC)  begin n_err++; $display("FAIL reset_pc got %h exp %h", pc, RESET_PC); end
    n_cmp++; if (id_instr !== NOP_WORD) begin n_err++; $display("FAIL reset_instr got %h exp %h", id_instr, NOP_WORD); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", id_valid); end
    n_cmp++; if (id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL reset_pp4 got %h exp 0", id_pc_plus4); end
    n_cmp++; if (irq_ack !== 1'b0 || exc_epc !== 32'h0) begin n_err++; $display("FAIL reset_exc got ack=%b epc=%h exp 0/0", irq_ack, exc_epc); end
    n_cmp++; if (fetch_count !== 32'h0) begin n_err++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
  endtask

  task automatic test_free_run();
    logic [31:0] words [4];
    words[0] = 32'h3c11_4000; words[1] = 32'h2631_0004;
    words[2] = 32'h3c11_4000; words[3] = 32'h2631_0004;
    for (int unsigned i = 0; i < 4; i++) begin
      n_cmp++;
      if (rom_addr !== RESET_PC + 32'(4 * i)) begin
        n_err++; $display("FAIL free_rom_addr[%0d] got %h exp %h", i, rom_addr, RESET_PC + 32'(4 * i));
      end
      if (i == 3) begin
        n_cmp++; if (fetch_count !== 32'd3) begin n_err++; $display("FAIL free_count got %0d exp 3", fetch_count); end
      end
      cycle();
      n_cmp++;
      if (id_instr !== words[i] || id_valid !== 1'b1 || id_pc_plus4 !== RESET_PC + 32'(4 * i + 4)) begin
        n_err++; $display("FAIL free_ifid[%0d] got %h/%b/%h exp %h/1/%h", i, id_instr, id_valid,
                          id_pc_plus4, words[i], RESET_PC + 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_instr, held_cnt;
    held_instr = id_instr; held_cnt = fetch_count;
    n_cmp++; if (pc !== 32'h8000_0010) begin n_err++; $display("FAIL stall_start_pc got %h exp 80000010", pc); end
    stall = 1;
    for (int unsigned i = 0; i < 2; i++) begin
      cycle();
      n_cmp++;
      if (pc !== 32'h8000_0010 || id_instr !== held_instr || fetch_count !== held_cnt || id_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold[%0d] got pc=%h instr=%h cnt=%0d exp pc=80000010 instr=%h cnt=%0d",
                          i, pc, id_instr, fetch_count, held_instr, held_cnt);
      end
    end
    stall = 0; cycle();
    n_cmp++; if (pc !== 32'h8000_0014) begin n_err++; $display("FAIL stall_release got %h exp 80000014", pc); end
  endtask

  task automatic test_flush_stall();
    logic [31:0] p;
    p = pc;
    flush = 1; stall = 1; cycle(); clr();
    n_cmp++;
    if (pc !== p || id_valid !== 1'b0 || id_instr !== NOP_WORD) begin
      n_err++; $display("FAIL flush_stall got pc=%h valid=%b instr=%h exp pc=%h valid=0 instr=%h", pc, id_valid, id_instr, p, NOP_WORD);
    end
  endtask

  task automatic test_branch_stall();
    jump = 1; jump_target = 32'h0000_0040; cycle(); clr();
    n_cmp++; if (pc !== 32'h0000_0040) begin n_err++; $display("FAIL br_setup got %h exp 00000040", pc); end
    br_taken = 1; br_target = 32'h0000_0054; stall = 1; cycle(); clr();
    n_cmp++;
    if (pc !== 32'h0000_0054 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL br_stall got pc=%h valid=%b exp 00000054/0", pc, id_valid);
    end
    cycle();
    n_cmp++;
    if (id_instr !== rom_mem[21] || id_valid !== 1'b1 || id_pc_plus4 !== 32'h0000_0058) begin
      n_err++; $display("FAIL br_fetch got %h/%b/%h exp %h/1/00000058", id_instr, id_valid, id_pc_plus4, rom_mem[21]);
    end
  endtask

  task automatic test_irq();
    jump = 1; jump_target = 32'h0000_0020; cycle(); clr();
    irq = 1; cycle();
    n_cmp++;
    if (pc !== XADR_PC || exc_epc !== 32'h0000_0020 || irq_ack !== 1'b1 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL irq_take got pc=%h epc=%h ack=%b valid=%b exp %h/00000020/1/0", pc, exc_epc, irq_ack, id_valid, XADR_PC);
    end
    cycle(); cycle();
    n_cmp++;
    if (irq_ack !== 1'b0 || exc_epc !== 32'h0000_0020 || pc !== XADR_PC + 32'd8) begin
      n_err++; $display("FAIL irq_masked got ack=%b epc=%h pc=%h exp 0/00000020/%h", irq_ack, exc_epc, pc, XADR_PC + 32'd8);
    end
    clr();
  endtask

  task automatic test_irq_jump();
    jump = 1; jump_target = 32'h0000_0040; cycle(); clr();
    irq = 1; jump = 1; jump_target = 32'h0000_0058; cycle();
    jump = 0;
    n_cmp++;
    if (pc !== 32'h0000_0058 || irq_ack !== 1'b0) begin
      n_err++; $display("FAIL irq_deferred got pc=%h ack=%b exp 00000058/0", pc, irq_ack);
    end
    cycle(); clr();
    n_cmp++;
    if (pc !== XADR_PC || exc_epc !== 32'h0000_0058 || irq_ack !== 1'b1) begin
      n_err++; $display("FAIL irq_after_jump got pc=%h epc=%h ack=%b exp %h/00000058/1", pc, exc_epc, irq_ack, XADR_PC);
    end
  endtask

  task automatic test_illop_reset();
    jump = 1; jump_target = 32'h0000_0010; cycle(); clr();
    illop = 1; br_taken = 1; br_target = 32'h0000_0100; irq = 1; cycle(); clr();
    n_cmp++;
    if (pc !== ILLOP_PC || irq_ack !== 1'b0 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL illop_prio got pc=%h ack=%b valid=%b exp %h/0/0", pc, irq_ack, id_valid, ILLOP_PC);
    end
    cycle(); cycle();
    stall = 1; cycle();
    reset = 1; jump = 1; jump_target = 32'h0000_0300; cycle(); clr();
    n_cmp++;
    if (pc !== RESET_PC || id_valid !== 1'b0 || id_instr !== NOP_WORD || id_pc_plus4 !== 32'h0 ||
        irq_ack !== 1'b0 || exc_epc !== 32'h0 || fetch_count !== 32'h0) begin
      n_err++; $display("FAIL reset_in_stall got pc=%h valid=%b instr=%h pp4=%h ack=%b epc=%h cnt=%0d exp reset values",
                        pc, id_valid, id_instr, id_pc_plus4, irq_ack, exc_epc, fetch_count);
    end
  endtask

  task automatic test_wrap();
    jump = 1; jump_target = 32'h7fff_fffc; cycle(); clr(); cycle();
    n_cmp++; if (pc !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_user got %h exp 00000000", pc); end
    jump = 1; jump_target = 32'hffff_fffc; cycle(); clr(); cycle();
    n_cmp++; if (pc !== 32'h8000_0000) begin n_err++; $display("FAIL wrap_super got %h exp 80000000", pc); end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      illop    = ($urandom_range(0, 19) == 0);
      irq      = ($urandom_range(0, 3) == 0);
      br_taken = ($urandom_range(0, 9) == 0);
      jr       = ($urandom_range(0, 15) == 0);
      jump     = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      br_target   = $urandom & 32'hffff_fffc;
      jr_target   = $urandom & 32'hffff_fffc;
      jump_target = $urandom & 32'hffff_fffc;
      n_cmp++;
      if (rom_addr !== m_pc) begin n_err++; $display("FAIL rnd_rom_addr[%0d] got %h exp %h", i, rom_addr, m_pc); end
      cycle();
      n_cmp++;
      if (pc !== m_pc || id_instr !== m_instr || id_pc_plus4 !== m_pp4 || id_valid !== m_valid ||
          irq_ack !== m_ack || exc_epc !== m_epc || fetch_count !== m_cnt) begin
        n_err++;
        $display("FAIL rnd_state[%0d] got pc=%h ins=%h pp4=%h v=%b ack=%b epc=%h cnt=%0d exp pc=%h ins=%h pp4=%h v=%b ack=%b epc=%h cnt=%0d",
                 i, pc, id_instr, id_pc_plus4, id_valid, irq_ack, exc_epc, fetch_count,
                 m_pc, m_instr, m_pp4, m_valid, m_ack, m_epc, m_cnt);
      end
    end
    clr();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h3c11_4000; rom_mem[1] = 32'h2631_0004;
    rom_mem[2] = 32'h3c11_4000; rom_mem[3] = 32'h2631_0004;
    test_reset();
    test_free_run();
    test_stall();
    test_flush_stall();
    test_branch_stall();
    test_irq();
    test_irq_jump();
    test_illop_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
